// File: rtl/vga_timing_pkg.sv
// Shared timing constants, coordinate type and helpers for the VGA timing
// generator. Totals and sync window bounds are computed by constant
// functions so every instance derives them the same way from its own
// parameter set.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  // Counters are 10 bits wide, so neither total may exceed this.
  localparam int unsigned COORD_LIMIT    = 1024;
  localparam int unsigned MAX_SYNC_DELAY = 4;

  // 640x480 @ 60 Hz with a 25 MHz pixel clock.
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FP      = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BP      = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FP      = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BP      = 33;

  function automatic int unsigned timing_total(input int unsigned visible,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    return visible + fp + sync + bp;
  endfunction

  // First count at which sync is asserted.
  function automatic int unsigned sync_start(input int unsigned visible,
                                             input int unsigned fp);
    return visible + fp;
  endfunction

  // First count after the sync pulse (exclusive upper bound).
  function automatic int unsigned sync_end(input int unsigned visible,
                                           input int unsigned fp,
                                           input int unsigned sync);
    return visible + fp + sync;
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay.sv
// sync_delay_line: 2-bit shift register carrying {hs, vs}.
// Always contains one output flop; DEPTH adds further stages on top of it,
// so the output lags the input by DEPTH+1 clock edges.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset; loads RST_VAL into every stage
//   d_i    - undelayed {hs, vs}
//   q_o    - delayed {hs, vs}
module sync_delay_line #(
  parameter int unsigned DEPTH   = 1,
  parameter logic [1:0]  RST_VAL = 2'b11
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] d_i,
  output logic [1:0] q_o
);

  logic [1:0] stage_q [DEPTH+1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i <= DEPTH; i++) begin
        stage_q[i] <= RST_VAL;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i <= DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH];

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: pixel scan counter and sync generator.
// Ports:
//   vga_clk     - pixel clock, one pixel per cycle
//   reset_n     - asynchronous active-low reset
//   DrawX       - horizontal count, 0..H_TOTAL-1
//   DrawY       - vertical count, 0..V_TOTAL-1
//   blank       - 1 while DrawX/DrawY address a visible pixel
//   hs, vs      - sync outputs, lagging DrawX/DrawY by SYNC_DELAY cycles
//   line_start  - pulse while DrawX==0
//   frame_start - pulse while DrawX==0 and DrawY==0
//   frame_count - completed-frame counter, wraps at 16 bits
// All outputs are registered. Qualifiers are decoded from the next-state
// counter values so they describe the pixel shown on DrawX/DrawY.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
  parameter int unsigned H_FP        = DEF_H_FP,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BP        = DEF_H_BP,
  parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
  parameter int unsigned V_FP        = DEF_V_FP,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BP        = DEF_V_BP,
  parameter int unsigned SYNC_DELAY  = 1,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned H_TOTAL = timing_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = timing_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT ||
      SYNC_DELAY > MAX_SYNC_DELAY) begin : g_param_check
    $error("vga_timing_gen: totals must be <= 1024 and SYNC_DELAY <= 4");
  end

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  // 11-bit bounds so a bound of exactly 1024 does not alias to 0.
  localparam logic [10:0] H_VIS_B   = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_B   = 11'(V_VISIBLE);
  localparam logic [10:0] HS_START  = 11'(sync_start(H_VISIBLE, H_FP));
  localparam logic [10:0] HS_END    = 11'(sync_end(H_VISIBLE, H_FP, H_SYNC));
  localparam logic [10:0] VS_START  = 11'(sync_start(V_VISIBLE, V_FP));
  localparam logic [10:0] VS_END    = 11'(sync_end(V_VISIBLE, V_FP, V_SYNC));
  localparam logic [1:0]  SYNC_IDLE = {2{~SYNC_ACTIVE}};

  coord_t      hc_q, hc_d;
  coord_t      vc_q, vc_d;
  logic        run_q;
  logic        blank_q, blank_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_count_q;
  logic        hs_raw, vs_raw;
  logic [1:0]  sync_q;

  // run_q is clear for the first edge after reset: that edge loads pixel
  // (0,0) with its strobes instead of advancing, so the first visible
  // cycle is the frame origin.
  always_comb begin
    hc_d = '0;
    vc_d = '0;
    if (run_q) begin
      if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + coord_t'(1);
      end else begin
        hc_d = hc_q + coord_t'(1);
        vc_d = vc_q;
      end
    end
  end

  always_comb begin
    blank_d       = ({1'b0, hc_d} < H_VIS_B) && ({1'b0, vc_d} < V_VIS_B);
    line_start_d  = (hc_d == '0);
    frame_start_d = (hc_d == '0) && (vc_d == '0);
    hs_raw = (({1'b0, hc_d} >= HS_START) && ({1'b0, hc_d} < HS_END))
             ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_raw = (({1'b0, vc_d} >= VS_START) && ({1'b0, vc_d} < VS_END))
             ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q         <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      run_q         <= 1'b1;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      // The origin strobe from the first edge is not a completed frame.
      if (run_q && frame_start_d) begin
        frame_count_q <= frame_count_q + 16'd1;
      end
    end
  end

  sync_delay_line #(
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .d_i    ({hs_raw, vs_raw}),
    .q_o    (sync_q)
  );

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign hs          = sync_q[1];
  assign vs          = sync_q[0];

endmodule
